// File: rtl/pipelined_rca.sv
// ---------------------------------------------------------------------------
// pipelined_rca
//   N-bit ripple-carry adder/subtractor whose carry chain is cut into STAGES
//   registered slices of W = N/STAGES bits each. Stage k resolves bits
//   [k*W +: W] from the carry registered by stage k-1. The not-yet-added
//   upper operand bits and the already-finished lower sum bits ride along in
//   every stage register so that each result leaves the pipe aligned.
//
//   The pipe stalls as a whole. It advances when the output register is
//   empty or is being drained. There is no bubble compression.
//
//   Handshake: a transfer happens on a rising clock edge where valid and
//   ready are both 1. in_valid/a/b/cin/sub must stay put while in_valid=1
//   and in_ready=0. out_valid/sum/cout/ovf hold while out_valid=1 and
//   out_ready=0. in_ready is combinational from out_ready.
//
// Parameters
//   N       operand/result width (N >= 1)
//   STAGES  number of slices = latency in cycles (1 <= STAGES <= N,
//           N % STAGES == 0)
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operand transaction present
//   in_ready   block accepts a transaction this cycle
//   a, b       operands, unsigned or two's complement
//   cin        carry-in (add) or borrow-in (sub)
//   sub        0 = a + b + cin, 1 = a - b - cin
//   out_valid  result present
//   out_ready  consumer accepts the result this cycle
//   sum        result bits
//   cout       carry-out (add) or NOT-borrow (sub)
//   ovf        signed overflow
// ---------------------------------------------------------------------------
module pipelined_rca #(
    parameter int N      = 8,
    parameter int STAGES = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    input  logic         sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] sum,
    output logic         cout,
    output logic         ovf
);

    localparam int W = N / STAGES;

    if (STAGES < 1 || STAGES > N || (N % STAGES) != 0) begin : g_bad_params
        $error("pipelined_rca: STAGES must divide N and lie in 1..N");
    end

    // Global stall: everything moves when the output slot is free or being
    // drained this cycle.
    logic advance;
    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    // Per-stage overflow candidate; only the last stage's value matters.
    logic [STAGES-1:0] ovf_tap;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        // Inputs to this stage's slice adder.
        logic [N-1:0] a_in;
        logic [N-1:0] b_in;
        logic [N-1:0] s_in;
        logic         c_in;
        logic         v_in;

        // Combinational slice results.
        logic [N-1:0] s_nxt;
        logic         c_nxt;
        logic         c_msb_in;

        // Stage registers.
        logic [N-1:0] a_q;
        logic [N-1:0] b_q;
        logic [N-1:0] s_q;
        logic         c_q;
        logic         v_q;

        if (k == 0) begin : g_first
            // Subtraction is a + ~b + ~cin: invert once at entry so every
            // later slice is a plain adder working on effective operands.
            assign a_in = a;
            assign b_in = sub ? ~b : b;
            assign c_in = sub ? ~cin : cin;
            assign s_in = '0;
            assign v_in = in_valid;
        end else begin : g_next
            assign a_in = g_stage[k-1].a_q;
            assign b_in = g_stage[k-1].b_q;
            assign s_in = g_stage[k-1].s_q;
            assign c_in = g_stage[k-1].c_q;
            assign v_in = g_stage[k-1].v_q;
        end

        // Ripple through this slice only; bits outside it pass unchanged.
        // c_msb_in ends up as the carry into the slice's top bit, which for
        // the last stage is the carry into bit N-1.
        always_comb begin
            s_nxt    = s_in;
            c_nxt    = c_in;
            c_msb_in = c_in;
            for (int i = 0; i < W; i++) begin
                c_msb_in         = c_nxt;
                s_nxt[k*W + i]   = a_in[k*W + i] ^ b_in[k*W + i] ^ c_nxt;
                c_nxt            = (a_in[k*W + i] & b_in[k*W + i]) |
                                   (c_nxt & (a_in[k*W + i] ^ b_in[k*W + i]));
            end
        end

        assign ovf_tap[k] = c_msb_in ^ c_nxt;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                v_q <= 1'b0;
                a_q <= '0;
                b_q <= '0;
                s_q <= '0;
                c_q <= 1'b0;
            end else if (advance) begin
                v_q <= v_in;
                a_q <= a_in;
                b_q <= b_in;
                s_q <= s_nxt;
                c_q <= c_nxt;
            end
        end
    end

    // Overflow is only meaningful once the top bit is resolved, so it gets
    // its own register alongside the last stage.
    logic ovf_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (advance) begin
            ovf_q <= ovf_tap[STAGES-1];
        end
    end

    assign out_valid = g_stage[STAGES-1].v_q;
    assign sum       = g_stage[STAGES-1].s_q;
    assign cout      = g_stage[STAGES-1].c_q;
    assign ovf       = ovf_q;

    // The last stage's operand copies and the non-final overflow taps have
    // no consumer; fold them into one sink so the intent is explicit.
    logic unused_sink;
    assign unused_sink = ^{g_stage[STAGES-1].a_q, g_stage[STAGES-1].b_q, ovf_tap};

endmodule
